// File: rtl/icache_dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_dm_pkg
//  Description : Shared widths and FSM state encoding for the direct-mapped
//                instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_dm_pkg;

  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 16;

  // Default address split: offset [3:2], index [7:4], tag [31:8]
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = DATA_W - OFF_W - IDX_W - 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/icache_dm_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_dm_if
//  Description : Fetch-side and refill-side signal bundle of the instruction
//                cache. The cache is the slave; core + memory are the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface icache_dm_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] pc_i;
  logic [DATA_W-1:0] instr_o;
  logic              instr_valid_o;
  logic              flush_i;
  logic              mem_req_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_rvalid_i;

  modport slave (
    input  pc_i, flush_i, mem_rdata_i, mem_rvalid_i,
    output instr_o, instr_valid_o, mem_req_o, mem_addr_o
  );

  modport master (
    output pc_i, flush_i, mem_rdata_i, mem_rvalid_i,
    input  instr_o, instr_valid_o, mem_req_o, mem_addr_o
  );
endinterface
`default_nettype wire

// File: rtl/icache_dm_store.sv
`default_nettype none
// ============================================================================
//  Module      : icache_dm_store
//  Description : Valid/tag/data arrays of the cache. One combinational read
//                port, one word write port with tag write + valid set, and a
//                global invalidate. Only the valid bits are reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_dm_store #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16,
  parameter int TAG_W      = 24
) (
  input  wire logic                          clk,
  input  wire logic                          rst_n,
  // lookup port
  input  wire logic [$clog2(NUM_LINES)-1:0]  i_rd_idx,
  input  wire logic [$clog2(LINE_WORDS)-1:0] i_rd_off,
  output logic                               o_rd_valid,
  output logic [TAG_W-1:0]                   o_rd_tag,
  output logic [DATA_W-1:0]                  o_rd_word,
  // refill port
  input  wire logic                          i_wr_en,
  input  wire logic [$clog2(NUM_LINES)-1:0]  i_wr_idx,
  input  wire logic [$clog2(LINE_WORDS)-1:0] i_wr_off,
  input  wire logic [DATA_W-1:0]             i_wr_data,
  input  wire logic                          i_tag_wr,
  input  wire logic [TAG_W-1:0]              i_tag,
  input  wire logic                          i_set_valid,
  input  wire logic                          i_inval
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [DATA_W-1:0]    r_data [NUM_LINES][LINE_WORDS];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_word  = r_data[i_rd_idx][i_rd_off];

  // Valid bits: invalidate beats a simultaneous line completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_inval) begin
      r_valid <= '0;
    end else if (i_tag_wr && i_set_valid) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are qualified by the valid bits, so no reset
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    end
    if (i_tag_wr) begin
      r_tag[i_wr_idx] <= i_tag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module      : icache_dm
//  Description : Direct-mapped read-only instruction cache. 0-cycle hit path
//                to the fetch stage; misses refill a whole line one beat at a
//                time with a single outstanding request.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_dm #(
  parameter int DATA_W     = icache_dm_pkg::DATA_W,
  parameter int LINE_WORDS = icache_dm_pkg::LINE_WORDS,
  parameter int NUM_LINES  = icache_dm_pkg::NUM_LINES
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  icache_dm_if.slave bus
);
  import icache_dm_pkg::*;

  localparam int c_OFF_W = $clog2(LINE_WORDS);
  localparam int c_IDX_W = $clog2(NUM_LINES);
  localparam int c_LO    = c_OFF_W + 2;
  localparam int c_TAG_W = DATA_W - c_LO - c_IDX_W;

  state_t               r_state;
  logic [c_OFF_W-1:0]   r_beat;
  logic [c_IDX_W-1:0]   r_base_idx;
  logic [c_TAG_W-1:0]   r_base_tag;
  logic                 r_discard;
  logic                 r_req;
  logic [DATA_W-1:0]    r_addr;

  logic [c_OFF_W-1:0]   w_off;
  logic [c_IDX_W-1:0]   w_idx;
  logic [c_TAG_W-1:0]   w_tag;
  logic                 w_rd_valid;
  logic [c_TAG_W-1:0]   w_rd_tag;
  logic [DATA_W-1:0]    w_rd_word;
  logic                 w_hit;
  logic                 w_take;
  logic                 w_last;
  logic                 w_unused;

  assign w_off    = bus.pc_i[c_LO-1:2];
  assign w_idx    = bus.pc_i[c_LO+c_IDX_W-1:c_LO];
  assign w_tag    = bus.pc_i[DATA_W-1:c_LO+c_IDX_W];
  assign w_unused = ^bus.pc_i[1:0];

  // Lookup is blocked during a refill: no bypass of the arriving word
  assign w_hit  = w_rd_valid && (w_rd_tag == w_tag) && (r_state == ST_IDLE);
  assign w_take = (r_state == ST_REFILL) && bus.mem_rvalid_i;
  assign w_last = w_take && (r_beat == c_OFF_W'(LINE_WORDS - 1));

  assign bus.instr_valid_o = w_hit;
  assign bus.instr_o       = w_hit ? w_rd_word : '0;
  assign bus.mem_req_o     = r_req;
  assign bus.mem_addr_o    = r_addr;

  icache_dm_store #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .TAG_W      (c_TAG_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (w_idx),
    .i_rd_off    (w_off),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_word   (w_rd_word),
    .i_wr_en     (w_take),
    .i_wr_idx    (r_base_idx),
    .i_wr_off    (r_beat),
    .i_wr_data   (bus.mem_rdata_i),
    .i_tag_wr    (w_last),
    .i_tag       (r_base_tag),
    // a flush on the last beat must also leave the line invalid
    .i_set_valid (!r_discard && !bus.flush_i),
    .i_inval     (bus.flush_i)
  );

  // Refill FSM with registered request/address; the address walks base+4*beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_beat     <= '0;
      r_base_idx <= '0;
      r_base_tag <= '0;
      r_discard  <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.flush_i && !w_hit) begin
            r_state    <= ST_REFILL;
            r_beat     <= '0;
            r_base_idx <= w_idx;
            r_base_tag <= w_tag;
            r_discard  <= 1'b0;
            r_req      <= 1'b1;
            r_addr     <= {w_tag, w_idx, {c_LO{1'b0}}};
          end
        end
        ST_REFILL: begin
          if (bus.flush_i) begin
            r_discard <= 1'b1;
          end
          if (bus.mem_rvalid_i) begin
            if (w_last) begin
              r_state   <= ST_IDLE;
              r_beat    <= '0;
              r_discard <= 1'b0;
              r_req     <= 1'b0;
              r_addr    <= '0;
            end else begin
              r_beat <= r_beat + c_OFF_W'(1);
              r_addr <= r_addr + DATA_W'(4);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_dm
//  Description : Randomised scoreboard bench for icache_dm against a
//                line-presence model and an address-hash instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_icache_dm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_dm_if #(.DATA_W(32)) bus();

  icache_dm #(
    .DATA_W     (32),
    .LINE_WORDS (4),
    .NUM_LINES  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          hit;
    int          refills;
    int          extra;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] exp_addr[$];
  int          checks = 0;
  int          errors = 0;
  bit          m_valid[16];
  logic [23:0] m_tag[16];
  int          wmin = 0;
  int          wmax = 0;
  bit          flush_arm = 1'b0;
  int          beat_cycles = 0;
  int          beats_done = 0;
  bit          active = 1'b0;
  int          done = 0;
  int          cyc = 0;

  // Instruction memory contents: a fixed hash of the word address
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: random wait states, checks beat addresses, can inject a
  // flush together with beat 2 of a refill
  initial begin : responder
    int          wl;
    int          bidx;
    logic [31:0] cap;
    wl = -1; bidx = 0; cap = '0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.flush_i      = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.mem_rvalid_i = 1'b0;
      bus.flush_i      = 1'b0;
      if (!rst_n) begin
        wl = -1; bidx = 0;
      end else if (bus.mem_req_o) begin
        if (wl < 0) begin
          wl = int'($urandom_range(wmax, wmin));
          beat_cycles += 1 + wl;
          cap = bus.mem_addr_o;
        end
        if (wl == 0) begin
          chk("addr_stable", bus.mem_addr_o, cap);
          if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got addr %h expected no request", bus.mem_addr_o);
          end else begin
            chk("beat_addr", bus.mem_addr_o, exp_addr.pop_front());
          end
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = mem_fn(bus.mem_addr_o);
          if (flush_arm && bidx == 2) begin
            bus.flush_i = 1'b1;
            flush_arm   = 1'b0;
          end
          bidx = (bidx + 1) % 4;
          beats_done++;
          wl = -1;
        end else begin
          wl--;
        end
      end
    end
  end

  // Fetch monitor: pops the scoreboard when the cache presents a hit
  initial begin : monitor
    txn_t t;
    int   exp_lat;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!bus.mem_req_o)     chk("idle_addr_zero", bus.mem_addr_o, 32'h0);
        if (!bus.instr_valid_o) chk("instr_zero_on_miss", bus.instr_o, 32'h0);
        if (active) begin
          cyc++;
          if (bus.instr_valid_o) begin
            t = sb.pop_front();
            chk("instr_data", bus.instr_o, t.data);
            exp_lat = t.hit ? 1 : (t.extra + t.refills + beat_cycles + 1);
            chk("fetch_latency", 32'(cyc), 32'(exp_lat));
            active = 1'b0;
            cyc = 0;
            done++;
          end
        end
      end
    end
  end

  // Issue one fetch and wait for it to be served; the model tracks which
  // line occupies each index
  task automatic fetch(input logic [31:0] pc, input bit fl_before_in,
                       input bit fl_mid, input bit rel_rst);
    txn_t        t;
    int          idx;
    logic [23:0] tg;
    logic [31:0] base;
    int          d0;
    bit          ok;
    bit          fl_before;
    idx  = int'(pc[7:4]);
    tg   = pc[31:8];
    base = {pc[31:4], 4'h0};
    if (rel_rst) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    t.hit = m_valid[idx] && (m_tag[idx] == tg);
    // a flush alongside a hitting pc would leave the held pc refilling on its own
    fl_before = fl_before_in && !t.hit;
    if (fl_before) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    t.pc      = pc;
    t.data    = mem_fn({pc[31:2], 2'b00});
    t.refills = t.hit ? 0 : (fl_mid ? 2 : 1);
    t.extra   = fl_before ? 1 : 0;
    for (int r = 0; r < t.refills; r++)
      for (int k = 0; k < 4; k++) exp_addr.push_back(base + 32'(4 * k));
    @(posedge clk); #2;
    beat_cycles = 0;
    if (!t.hit && fl_mid) flush_arm = 1'b1;
    sb.push_back(t);
    bus.pc_i = pc;
    if (fl_before) bus.flush_i = 1'b1;
    if (rel_rst) rst_n = 1'b1;
    active = 1'b1;
    d0 = done;
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk); #1;
      ok = (done != d0);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: pc %h got no instr_valid_o, required within 400 cycles", pc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    if (fl_mid && !t.hit) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
  endtask

  initial begin : stimulus
    int  b0;
    bit  ok;
    logic [31:0] pc;
    bit  fb;
    bit  fm;
    bus.pc_i = '0;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid_o), 32'h0);
    chk("rst_instr", bus.instr_o, 32'h0);

    // cold miss, single-cycle memory, then same-line hit and a second index
    wmin = 0; wmax = 0;
    fetch(32'h100, 0, 0, 1);
    fetch(32'h10C, 0, 0, 0);
    fetch(32'h110, 0, 0, 0);
    fetch(32'h114, 0, 0, 0);
    // three wait states per beat, conflict eviction on index 0
    wmin = 3; wmax = 3;
    fetch(32'h200, 0, 0, 0);
    fetch(32'h118, 0, 0, 0);
    fetch(32'h104, 0, 0, 0);
    fetch(32'h208, 0, 0, 0);
    // flush beside a miss, then both earlier lines miss
    wmin = 0; wmax = 1;
    fetch(32'h120, 1, 0, 0);
    fetch(32'h100, 0, 0, 0);
    fetch(32'h110, 0, 0, 0);
    // flush arriving with beat 2 of a refill
    fetch(32'h400, 0, 1, 0);
    fetch(32'h404, 0, 0, 0);

    // reset while beat 1 is outstanding
    wmin = 0; wmax = 0;
    b0 = beats_done;
    exp_addr.push_back(32'h300);
    exp_addr.push_back(32'h304);
    @(posedge clk); #2;
    bus.pc_i = 32'h300;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = (beats_done >= b0 + 2);
    end
    chk("reset_mid_reached_beat1", 32'(ok), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("rstmid_instr_valid", 32'(bus.instr_valid_o), 32'h0);
    chk("rstmid_mem_addr", bus.mem_addr_o, 32'h0);
    exp_addr.delete();
    repeat (2) @(posedge clk);
    fetch(32'h300, 0, 0, 1);

    // randomised traffic over four tags to mix hits, misses and evictions
    wmin = 0; wmax = 3;
    for (int i = 0; i < 150; i++) begin
      pc = 32'($urandom_range(0, 255)) << 2;
      fb = ($urandom_range(0, 9) == 0);
      fm = !fb && ($urandom_range(0, 11) == 0);
      fetch(pc, fb, fm, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the pipelined core's fetch stage and slow instruction memory.
- Core drives pc and consumes instr in the same cycle, as with the current combinational instruction memory.
- New signal instr_valid tells the core to hold its fetch-stage stall while a miss is being serviced.
- Misses are refilled one whole line at a time through a single-outstanding-beat request/valid handshake.

Parameters:
- DATA_W, 32, instruction/address width.
- LINE_WORDS, 4, words per line (power of 2, >=2).
- NUM_LINES, 16, lines in cache (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_i  in  DATA_W  fetch address from core; bits [1:0] ignored.
- instr_o  out  DATA_W  instruction at pc_i on hit, else 0.
- instr_valid_o  out  1  1 = hit, instr_o usable this cycle; 0 = core must stall fetch.
- flush_i  in  1  one-cycle pulse; invalidate entire cache.
- mem_req_o  out  1  refill beat request.
- mem_addr_o  out  DATA_W  word address of requested beat, word aligned.
- mem_rdata_i  in  DATA_W  returned word.
- mem_rvalid_i  in  1  mem_rdata_i valid; completes the current beat.

Behaviour:
- Address split, widths from parameters:
  - OFF = log2(LINE_WORDS) bits at pc[OFF+1:2].
  - IDX = log2(NUM_LINES) bits directly above the offset.
  - TAG = remaining upper bits.
  - Defaults: offset [3:2], index [7:4], tag [31:8], 24 bits.
- Storage:
  - Per line: valid bit, tag, and LINE_WORDS data words, all flops.
  - Only the valid bits are reset.
- Hit (combinational, 0-cycle latency):
  - hit = valid[idx] & tag[idx]==pc tag & state==IDLE.
  - instr_valid_o = hit; instr_o = hit ? data[idx][off] : 0.
- FSM states IDLE, REFILL.
  - IDLE, no hit, no flush_i: latch the line base (pc with offset and [1:0] zeroed), beat counter <= 0, go to REFILL. Miss-to-REFILL takes 1 cycle.
  - REFILL, beat handling:
    - mem_req_o = 1; mem_addr_o = base + 4*beat.
    - mem_addr_o is held stable until mem_rvalid_i.
    - Each cycle with mem_rvalid_i: write mem_rdata_i into data[base idx][beat], then beat += 1.
    - mem_rvalid_i while not in REFILL is ignored.
  - REFILL, last beat (beat==LINE_WORDS-1 with mem_rvalid_i):
    - Write tag; set valid unless the discard flag is set; clear discard; go to IDLE.
    - Next cycle, a pc in that line hits.
  - Minimum miss penalty: 1 + LINE_WORDS cycles with single-cycle memory.
- Outputs outside REFILL: mem_req_o = 0, mem_addr_o = 0.
- pc_i changes during REFILL (e.g. core redirect): the refill still completes for the latched line; lookup then re-evaluates in IDLE.
- flush_i:
  - Any state: all valid bits cleared next edge.
  - In REFILL: set the discard flag. Remaining beats are still taken, so no orphan rvalid, but the line is left invalid.
  - In IDLE the same cycle as a miss: flush wins, no refill starts that cycle.
- Reset (async):
  - All valid = 0, state = IDLE, beat = 0, discard = 0.
  - mem_req_o = 0, mem_addr_o = 0, instr_valid_o = 0, instr_o = 0.
  - Reset mid-refill abandons the transaction; memory is reset with the core.
- Simultaneous last-beat write and lookup: instr_valid_o stays 0 that cycle because state==REFILL. There is no bypass of the arriving word.

Decomposition:
- Shared package/header, next to the existing def.h:
  - DATA_W.
  - FSM state encodings IDLE/REFILL.
  - Derived widths OFF_W, IDX_W, TAG_W.
- One natural sub-module: icache_dm_store.
  - Holds the valid/tag/data arrays.
  - Single combinational read port, single write port (word write, tag write + valid set, global invalidate).
  - The top level keeps the FSM, beat counter, discard flag and handshake.

Test Plan:
- Cold miss: reset, pc=0x100, memory returns 0xA0..0xA3 with 1-cycle rvalid.
  - mem_addr_o steps 0x100, 0x104, 0x108, 0x10C.
  - instr_valid_o=0 for 5 cycles, then 1 with instr_o=0xA0.
  - pc=0x10C then hits with 0xA3 at 0 latency.
- Memory wait states: rvalid 3 cycles after each req.
  - mem_addr_o stays stable across waits; fill completes after 12 beat-cycles; contents correct.
- Conflict eviction: fill 0x100, then fetch 0x200 (same index 0, new tag).
  - 0x200 misses and refills; returning to 0x100 misses again.
  - Different index 0x110 remains a hit throughout.
- Flush: with lines 0x100 and 0x110 valid, pulse flush_i.
  - Both miss next cycle.
  - Flush during beat 2 of a refill: beats 2-3 still requested; line ends invalid; same pc misses again.
- Reset mid-refill: assert rst_n=0 at beat 1.
  - mem_req_o=0 and instr_valid_o=0 immediately (async).
  - After release, the same pc starts a fresh refill from beat 0.
- Pipeline integration: run the existing core program through icache_dm, stall driven by ~instr_valid_o.
  - Architectural register/memory results identical to the combinational-instruction-memory run.
